fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the decode stage. Holds the program counter and issues in-order word fetches to instruction memory over a ready/valid handshake with variable latency. Buffers returned words in a small FIFO and presents them, with their PC, to decode through a valid/ready interface. Redirects from branch/jump resolution flush the buffer and drop in-flight responses.

---
 rtl/fetch_unit.sv | 218 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage. Holds the program counter, issues
//             in-order word fetches to instruction memory over a ready/valid
//             handshake with variable latency, buffers the returned words
//             together with their PC, and hands them to decode through a
//             valid/ready interface. A redirect flushes the buffer, restarts
//             fetching at the new address and discards every response that
//             is still in flight.
//
//  Ports    :
//    clk           in   1   clock, rising edge
//    rst           in   1   asynchronous reset, active low
//    imemReq       out  1   fetch request valid
//    imemAddr      out  32  fetch word address (bits [1:0] always 0)
//    imemReady     in   1   memory accepts the request this cycle
//    imemValid     in   1   response word valid (returned in request order)
//    imemData      in   32  response instruction word
//    redirect      in   1   one-cycle pulse: restart fetch at redirectPc
//    redirectPc    in   32  new fetch address (bits [1:0] ignored)
//    instr         out  32  instruction word to decode
//    instrPc       out  32  address of instr
//    instrPcPlus4  out  32  instrPc + 4 (mod 2^32)
//    instrValid    out  1   instr / instrPc valid
//    instrReady    in   1   decode accepts instr this cycle
//
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemReady,
   input  logic        imemValid,
   input  logic [31:0] imemData,
   input  logic        redirect,
   input  logic [31:0] redirectPc,
   output logic [31:0] instr,
   output logic [31:0] instrPc,
   output logic [31:0] instrPcPlus4,
   output logic        instrValid,
   input  logic        instrReady
);

   // BUF_DEPTH is a power of two, so the pointers wrap naturally.
   localparam int               PTR_W     = $clog2(BUF_DEPTH);
   localparam int               CNT_W     = $clog2(BUF_DEPTH + 1);
   localparam int               SUM_W     = CNT_W + 1;
   localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(BUF_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [31:0]      pc_q, pc_d;

   // Instruction buffer: returned words paired with their fetch address.
   logic [31:0]      buf_word_q [BUF_DEPTH];
   logic [31:0]      buf_pc_q   [BUF_DEPTH];
   logic [PTR_W-1:0] buf_rd_q, buf_rd_d;
   logic [PTR_W-1:0] buf_wr_q, buf_wr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Addresses of accepted-but-not-returned requests, oldest first.
   logic [31:0]      pcq_q [BUF_DEPTH];
   logic [PTR_W-1:0] pcq_rd_q, pcq_rd_d;
   logic [PTR_W-1:0] pcq_wr_q, pcq_wr_d;

   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   // -------------------------------------------------------------------------
   // Handshake decode
   // -------------------------------------------------------------------------
   logic             w_pop;
   logic             w_accept;
   logic             w_resp;
   logic             w_drop_old;
   logic             w_push;
   logic [SUM_W-1:0] w_credit_used;
   logic             w_unused;

   // The low address bits of a redirect target are forced to zero.
   assign w_unused = ^redirectPc[1:0];

   assign instrValid = (count_q != '0);
   assign w_pop      = instrValid && instrReady;

   // Credits in use: buffered entries plus outstanding requests. The entry
   // being handed to decode this cycle is already free for a response that
   // can arrive no earlier than next cycle; counting it as free is what
   // allows one instruction per cycle with a single-cycle memory.
   assign w_credit_used = {1'b0, count_q} - {{CNT_W{1'b0}}, w_pop}
                        + {1'b0, inflight_q};

   assign imemReq  = rst && !redirect && (w_credit_used < DEPTH_SUM);
   assign imemAddr = pc_q;
   assign w_accept = imemReq && imemReady;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign w_resp     = imemValid && (inflight_q != '0);
   assign w_drop_old = w_resp && (drop_q != '0);
   // A response coinciding with a redirect belongs to the old stream.
   assign w_push     = w_resp && !w_drop_old && !redirect;

   assign instr        = buf_word_q[buf_rd_q];
   assign instrPc      = buf_pc_q[buf_rd_q];
   assign instrPcPlus4 = instrPc + 32'd4;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      pc_d       = pc_q;
      buf_rd_d   = buf_rd_q;
      buf_wr_d   = buf_wr_q;
      count_d    = count_q;
      pcq_rd_d   = pcq_rd_q;
      pcq_wr_d   = pcq_wr_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;

      if (w_accept) begin
         pc_d     = pc_q + 32'd4;
         pcq_wr_d = pcq_wr_q + PTR_ONE;
      end

      if (w_resp) begin
         pcq_rd_d = pcq_rd_q + PTR_ONE;
      end

      case ({w_accept, w_resp})
         2'b10:   inflight_d = inflight_q + CNT_ONE;
         2'b01:   inflight_d = inflight_q - CNT_ONE;
         default: inflight_d = inflight_q;
      endcase

      if (w_push) begin
         buf_wr_d = buf_wr_q + PTR_ONE;
      end

      if (w_pop) begin
         buf_rd_d = buf_rd_q + PTR_ONE;
      end

      case ({w_push, w_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (w_drop_old) begin
         drop_d = drop_q - CNT_ONE;
      end

      // Redirect: empty the buffer (no push happens this cycle, so the write
      // pointer is already final) and mark every still-outstanding request
      // as stale. No request is issued this cycle, so pc is free to reload.
      if (redirect) begin
         pc_d     = {redirectPc[31:2], 2'b00};
         buf_rd_d = buf_wr_q;
         count_d  = '0;
         drop_d   = inflight_d;
      end
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q       <= RESET_PC;
         buf_rd_q   <= '0;
         buf_wr_q   <= '0;
         count_q    <= '0;
         pcq_rd_q   <= '0;
         pcq_wr_q   <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         pc_q       <= pc_d;
         buf_rd_q   <= buf_rd_d;
         buf_wr_q   <= buf_wr_d;
         count_q    <= count_d;
         pcq_rd_q   <= pcq_rd_d;
         pcq_wr_q   <= pcq_wr_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   // Storage is cleared on reset so instr / instrPc read as zero afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_word_q[i] <= '0;
            buf_pc_q[i]   <= '0;
            pcq_q[i]      <= '0;
         end
      end else begin
         if (w_accept) begin
            pcq_q[pcq_wr_q] <= pc_q;
         end
         if (w_push) begin
            buf_word_q[buf_wr_q] <= imemData;
            buf_pc_q[buf_wr_q]   <= pcq_q[pcq_rd_q];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit. A small in-order
//             memory model with programmable latency answers fetches of the
//             main instance; a second instance with RESET_PC near the top of
//             the address space is driven by hand for the wrap case.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        imemReq, imemReady, imemValid, redirect, instrValid, instrReady;
   logic [31:0] imemAddr, imemData, redirectPc, instr, instrPc, instrPcPlus4;

   logic        imemReq2, imemReady2, imemValid2, redirect2, instrValid2, instrReady2;
   logic [31:0] imemAddr2, imemData2, redirectPc2, instr2, instrPc2, instrPcPlus42;

   int          passed = 0;
   int          total  = 0;
   int          cyc    = 0;
   int          lat    = 1;
   logic [31:0] q_addr [$];
   int          q_due  [$];

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
      .clk(clk), .rst(rst),
      .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady),
      .imemValid(imemValid), .imemData(imemData),
      .redirect(redirect), .redirectPc(redirectPc),
      .instr(instr), .instrPc(instrPc), .instrPcPlus4(instrPcPlus4),
      .instrValid(instrValid), .instrReady(instrReady)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_dut_wrap (
      .clk(clk), .rst(rst),
      .imemReq(imemReq2), .imemAddr(imemAddr2), .imemReady(imemReady2),
      .imemValid(imemValid2), .imemData(imemData2),
      .redirect(redirect2), .redirectPc(redirectPc2),
      .instr(instr2), .instrPc(instrPc2), .instrPcPlus4(instrPcPlus42),
      .instrValid(instrValid2), .instrReady(instrReady2)
   );

   // Memory contents: word at address a. Address 0 holds 0x2002_0005.
   function automatic logic [31:0] mdata(input logic [31:0] a);
      return 32'h2002_0005 + (a << 8);
   endfunction

   // Advance one clock; the memory model records the accepted request and
   // presents the oldest response once its latency has elapsed.
   task automatic step();
      logic        acc;
      logic        rsp;
      logic [31:0] a;
      logic [31:0] dummy_a;
      int          dummy_d;
      acc = imemReq && imemReady;
      rsp = imemValid;
      a   = imemAddr;
      @(posedge clk);
      #1;
      cyc++;
      if (rsp && q_addr.size() > 0) begin
         dummy_a = q_addr.pop_front();
         dummy_d = q_due.pop_front();
      end
      if (acc) begin
         q_addr.push_back(a);
         q_due.push_back(cyc - 1 + lat);
      end
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
         imemValid = 1'b1;
         imemData  = mdata(q_addr[0]);
      end else begin
         imemValid = 1'b0;
         imemData  = 32'h0;
      end
      redirect = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      redirect = 1'b0; redirectPc = 32'h0; imemReady = 1'b0; instrReady = 1'b0;
      imemValid = 1'b0; imemData = 32'h0;
      redirect2 = 1'b0; redirectPc2 = 32'h0; imemReady2 = 1'b0; instrReady2 = 1'b0;
      imemValid2 = 1'b0; imemData2 = 32'h0;
      q_addr.delete();
      q_due.delete();
      repeat (3) step();
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      lat = 1; imemReady = 1'b1; instrReady = 1'b0;
      #1;
      repeat (3) step();
      // Assert reset mid-operation: state must clear without a clock edge.
      rst = 1'b0;
      #1;
      total++; if (imemReq !== 1'b0) $display("FAIL rst_async_req: got %b want 0", imemReq); else passed++;
      total++; if (instrValid !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", instrValid); else passed++;
      total++; if (instr !== 32'h0) $display("FAIL rst_instr: got %h want 00000000", instr); else passed++;
      total++; if (instrPc !== 32'h0) $display("FAIL rst_instrPc: got %h want 00000000", instrPc); else passed++;
      total++; if (instrPcPlus4 !== 32'h4) $display("FAIL rst_pcplus4: got %h want 00000004", instrPcPlus4); else passed++;
      q_addr.delete(); q_due.delete(); imemValid = 1'b0;
      repeat (3) step();
      total++; if (imemReq !== 1'b0) $display("FAIL rst_hold_req: got %b want 0", imemReq); else passed++;
      rst = 1'b1;
      #1;
      total++; if (imemReq !== 1'b1) $display("FAIL rst_first_req: got %b want 1", imemReq); else passed++;
      total++; if (imemAddr !== 32'h0) $display("FAIL rst_first_addr: got %h want 00000000", imemAddr); else passed++;
      step();
      total++; if (instrValid !== 1'b0) $display("FAIL rst_no_bypass: got %b want 0", instrValid); else passed++;
      step();
      total++; if (instrValid !== 1'b1) $display("FAIL rst_first_valid: got %b want 1", instrValid); else passed++;
      total++; if (instr !== 32'h2002_0005) $display("FAIL rst_first_instr: got %h want 20020005", instr); else passed++;
      total++; if (instrPc !== 32'h0) $display("FAIL rst_first_pc: got %h want 00000000", instrPc); else passed++;
      total++; if (instrPcPlus4 !== 32'h4) $display("FAIL rst_first_pc4: got %h want 00000004", instrPcPlus4); else passed++;
   endtask

   task automatic test_streaming();
      logic [31:0] exp_pc;
      do_reset();
      lat = 1; imemReady = 1'b1; instrReady = 1'b1;
      #1;
      step();
      step();
      for (int i = 0; i < 8; i++) begin
         exp_pc = 32'(i * 4);
         total++; if (instrValid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, instrValid); else passed++;
         total++; if (instrPc !== exp_pc) $display("FAIL stream_pc[%0d]: got %h want %h", i, instrPc, exp_pc); else passed++;
         total++; if (instr !== mdata(exp_pc)) $display("FAIL stream_instr[%0d]: got %h want %h", i, instr, mdata(exp_pc)); else passed++;
         total++; if (instrPcPlus4 !== exp_pc + 32'd4) $display("FAIL stream_pc4[%0d]: got %h want %h", i, instrPcPlus4, exp_pc + 32'd4); else passed++;
         step();
      end
   endtask

   task automatic test_backpressure();
      int          acc_n;
      int          n;
      logic [31:0] exp_pc;
      do_reset();
      lat = 1; imemReady = 1'b1; instrReady = 1'b0;
      #1;
      acc_n = 0;
      for (int c = 0; c < 7; c++) begin
         if (c >= 2) begin
            total++; if (imemReq !== 1'b0) $display("FAIL bp_req_low[%0d]: got %b want 0", c, imemReq); else passed++;
            total++; if (instrPc !== 32'h0) $display("FAIL bp_head_hold[%0d]: got %h want 00000000", c, instrPc); else passed++;
         end
         if (imemReq && imemReady) acc_n++;
         step();
      end
      total++; if (acc_n !== 2) $display("FAIL bp_outstanding: got %0d want 2", acc_n); else passed++;
      total++; if (instrValid !== 1'b1) $display("FAIL bp_valid: got %b want 1", instrValid); else passed++;
      instrReady = 1'b1;
      #1;
      exp_pc = 32'h0;
      n = 0;
      for (int c = 0; c < 20 && n < 6; c++) begin
         if (instrValid) begin
            total++; if (instrPc !== exp_pc) $display("FAIL bp_order_pc: got %h want %h", instrPc, exp_pc); else passed++;
            total++; if (instr !== mdata(exp_pc)) $display("FAIL bp_order_instr: got %h want %h", instr, mdata(exp_pc)); else passed++;
            exp_pc = exp_pc + 32'd4;
            n++;
         end
         step();
      end
      total++; if (n !== 6) $display("FAIL bp_delivered: got %0d want 6", n); else passed++;
   endtask

   task automatic test_redirect();
      logic done;
      logic got_req;
      do_reset();
      lat = 3; imemReady = 1'b1; instrReady = 1'b1;
      #1;
      step();
      step();
      // Two requests (0x0, 0x4) are now outstanding.
      redirect = 1'b1; redirectPc = 32'h0000_0103;
      #1;
      total++; if (imemReq !== 1'b0) $display("FAIL redir_noreq: got %b want 0", imemReq); else passed++;
      step();
      total++; if (imemAddr !== 32'h0000_0100) $display("FAIL redir_addr: got %h want 00000100", imemAddr); else passed++;
      total++; if (instrValid !== 1'b0) $display("FAIL redir_flush: got %b want 0", instrValid); else passed++;
      done = 1'b0;
      got_req = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         if (imemReq && imemReady && !got_req) begin
            got_req = 1'b1;
            total++; if (imemAddr !== 32'h0000_0100) $display("FAIL redir_first_req: got %h want 00000100", imemAddr); else passed++;
         end
         if (instrValid) begin
            done = 1'b1;
            total++; if (instrPc !== 32'h0000_0100) $display("FAIL redir_first_pc: got %h want 00000100", instrPc); else passed++;
            total++; if (instr !== mdata(32'h100)) $display("FAIL redir_first_instr: got %h want %h", instr, mdata(32'h100)); else passed++;
         end
         step();
      end
      total++; if (done !== 1'b1) $display("FAIL redir_timeout: got %b want 1", done); else passed++;
      total++; if (instrValid !== 1'b1 || instrPc !== 32'h0000_0104) $display("FAIL redir_second: got valid=%b pc=%h want valid=1 pc=00000104", instrValid, instrPc); else passed++;
   endtask

   task automatic test_redirect_coincident();
      do_reset();
      lat = 1; imemReady = 1'b1; instrReady = 1'b1;
      #1;
      step();
      step();
      // Head 0x0 is being taken by decode while the word for 0x4 arrives.
      redirect = 1'b1; redirectPc = 32'h0000_0200;
      #1;
      total++; if (instrValid !== 1'b1 || instrPc !== 32'h0) $display("FAIL coin_handoff: got valid=%b pc=%h want valid=1 pc=00000000", instrValid, instrPc); else passed++;
      total++; if (imemReq !== 1'b0) $display("FAIL coin_noreq: got %b want 0", imemReq); else passed++;
      step();
      total++; if (instrValid !== 1'b0) $display("FAIL coin_empty: got %b want 0", instrValid); else passed++;
      total++; if (imemReq !== 1'b1 || imemAddr !== 32'h0000_0200) $display("FAIL coin_newreq: got req=%b addr=%h want req=1 addr=00000200", imemReq, imemAddr); else passed++;
      step();
      total++; if (instrValid !== 1'b0) $display("FAIL coin_no_stale: got %b want 0", instrValid); else passed++;
      step();
      total++; if (instrValid !== 1'b1 || instrPc !== 32'h0000_0200) $display("FAIL coin_first_pc: got valid=%b pc=%h want valid=1 pc=00000200", instrValid, instrPc); else passed++;
      total++; if (instr !== mdata(32'h200)) $display("FAIL coin_first_instr: got %h want %h", instr, mdata(32'h200)); else passed++;
   endtask

   task automatic test_wrap();
      do_reset();
      imemReady2 = 1'b1;
      #1;
      total++; if (imemReq2 !== 1'b1 || imemAddr2 !== 32'hFFFF_FFF8) $display("FAIL wrap_addr0: got req=%b addr=%h want req=1 addr=fffffff8", imemReq2, imemAddr2); else passed++;
      @(posedge clk); #1;
      imemValid2 = 1'b1; imemData2 = 32'hDEAD_0001;
      #1;
      total++; if (imemReq2 !== 1'b1 || imemAddr2 !== 32'hFFFF_FFFC) $display("FAIL wrap_addr1: got req=%b addr=%h want req=1 addr=fffffffc", imemReq2, imemAddr2); else passed++;
      @(posedge clk); #1;
      imemValid2 = 1'b1; imemData2 = 32'hDEAD_0002; instrReady2 = 1'b1;
      #1;
      total++; if (imemAddr2 !== 32'h0000_0000) $display("FAIL wrap_addr2: got %h want 00000000", imemAddr2); else passed++;
      total++; if (instrValid2 !== 1'b1 || instrPc2 !== 32'hFFFF_FFF8) $display("FAIL wrap_pc0: got valid=%b pc=%h want valid=1 pc=fffffff8", instrValid2, instrPc2); else passed++;
      total++; if (instrPcPlus42 !== 32'hFFFF_FFFC) $display("FAIL wrap_pc4_0: got %h want fffffffc", instrPcPlus42); else passed++;
      total++; if (instr2 !== 32'hDEAD_0001) $display("FAIL wrap_instr0: got %h want dead0001", instr2); else passed++;
      @(posedge clk); #1;
      imemValid2 = 1'b0; imemReady2 = 1'b0;
      #1;
      total++; if (instrValid2 !== 1'b1 || instrPc2 !== 32'hFFFF_FFFC) $display("FAIL wrap_pc1: got valid=%b pc=%h want valid=1 pc=fffffffc", instrValid2, instrPc2); else passed++;
      total++; if (instrPcPlus42 !== 32'h0000_0000) $display("FAIL wrap_pc4_1: got %h want 00000000", instrPcPlus42); else passed++;
      total++; if (instr2 !== 32'hDEAD_0002) $display("FAIL wrap_instr1: got %h want dead0002", instr2); else passed++;
      @(posedge clk); #1;
      instrReady2 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_redirect();
      test_redirect_coincident();
      test_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passed, total);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
